axi4_traffic_gen: RTL and testbench

AXI4_TRAFFIC_GEN -- requirements
Module: axi4_traffic_gen

---
 rtl/axi4_traffic_gen.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi4_traffic_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_traffic_gen
//  Description : AXI4 master traffic generator. Each run issues NUM_BURSTS
//                INCR write bursts, each followed by a read-back burst of
//                the same address range. Write data is the beat byte
//                address. B/R response errors and rlast mismatches are
//                accumulated in a saturating error counter.
//  Options     : define AXI4_TG_CHECK_EN to also compare read data against
//                the written address pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_traffic_gen #(
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          DATA_W     = 32,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 4,
    parameter int          ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    // write address channel
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [ID_W-1:0]       awid,
    output logic                  awvalid,
    input  logic                  awready,
    // write data channel
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // write response channel
    input  logic [1:0]            bresp,
    input  logic [ID_W-1:0]       bid,
    input  logic                  bvalid,
    output logic                  bready,
    // read address channel
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_W-1:0]       arid,
    output logic                  arvalid,
    input  logic                  arready,
    // read data channel
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic [ID_W-1:0]       rid,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int          C_BYTES       = DATA_W / 8;
    localparam int          C_SIZE        = $clog2(C_BYTES);
    localparam logic [31:0] C_BURST_BYTES = 32'(BURST_LEN * C_BYTES);
    localparam logic [8:0]  C_LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [15:0] C_LAST_BURST  = 16'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_WD   = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_RD   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_k;
    logic [8:0]    r_beat;
    logic [31:0]   r_addr;
    logic [15:0]   r_err;

    logic          w_start_ok;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_beat_last;
    logic          w_rd_exit;
    logic          w_beat_clr;
    logic [31:0]   w_beat_addr;
    logic [DATA_W-1:0] w_pattern;

    logic          w_err_b;
    logic          w_err_rresp;
    logic          w_err_rlast;
    logic          w_err_data;
    logic [1:0]    w_err_inc;
    logic [16:0]   w_err_sum;
    logic [15:0]   w_err_next;
    logic          w_unused;

    // ------------------------------------------------------------------
    // Handshakes and shared address arithmetic
    // ------------------------------------------------------------------
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_aw_hs     = awvalid && awready;
    assign w_w_hs      = wvalid  && wready;
    assign w_b_hs      = bvalid  && bready;
    assign w_ar_hs     = arvalid && arready;
    assign w_r_hs      = rvalid  && rready;
    assign w_beat_last = (r_beat == C_LAST_BEAT);
    assign w_rd_exit   = w_r_hs && w_beat_last;

    // The beat counter restarts whenever an address phase is entered.
    assign w_beat_clr  = ((w_next == S_AW) && (r_state != S_AW)) ||
                         ((w_next == S_AR) && (r_state != S_AR));

    // Byte address of the current beat; doubles as write data pattern.
    assign w_beat_addr = r_addr + (32'(r_beat) << C_SIZE);
    assign w_pattern   = DATA_W'(w_beat_addr);

    // ------------------------------------------------------------------
    // Static payload fields
    // ------------------------------------------------------------------
    assign awaddr  = r_addr;
    assign awlen   = 8'(BURST_LEN - 1);
    assign awsize  = 3'(C_SIZE);
    assign awburst = 2'b01;
    assign awid    = '0;
    assign araddr  = r_addr;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'(C_SIZE);
    assign arburst = 2'b01;
    assign arid    = '0;
    assign wdata   = w_pattern;
    assign wstrb   = '1;
    assign err_cnt = r_err;

    // ------------------------------------------------------------------
    // Error detection
    // ------------------------------------------------------------------
    assign w_err_b     = w_b_hs && (bresp != 2'b00);
    assign w_err_rresp = w_r_hs && (rresp != 2'b00);
    assign w_err_rlast = w_r_hs && (rlast != w_beat_last);

`ifdef AXI4_TG_CHECK_EN
    assign w_err_data  = w_r_hs && (rdata != w_pattern);
    assign w_unused    = ^{bid, rid};
`else
    assign w_err_data  = 1'b0;
    assign w_unused    = ^{bid, rid, rdata};
`endif

    // B and R handshakes never coincide, so at most three terms add.
    assign w_err_inc  = {1'b0, w_err_b} + {1'b0, w_err_rresp} +
                        {1'b0, w_err_rlast} + {1'b0, w_err_data};
    assign w_err_sum  = {1'b0, r_err} + {15'd0, w_err_inc};
    assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

    // State register with asynchronous abandon on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and channel control decode
    always_comb begin
        w_next  = r_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                busy    = 1'b1;
                if (w_aw_hs) w_next = S_WD;
            end
            S_WD: begin
                wvalid  = 1'b1;
                wlast   = w_beat_last;
                busy    = 1'b1;
                if (w_w_hs && w_beat_last) w_next = S_B;
            end
            S_B: begin
                bready  = 1'b1;
                busy    = 1'b1;
                if (w_b_hs) w_next = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                busy    = 1'b1;
                if (w_ar_hs) w_next = S_RD;
            end
            S_RD: begin
                rready  = 1'b1;
                busy    = 1'b1;
                if (w_rd_exit) begin
                    w_next = (r_k == C_LAST_BURST) ? S_DONE : S_AW;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                if (start) w_next = S_AW;
            end
            default: begin
                w_next  = S_IDLE;
            end
        endcase
    end

    // Burst index, burst address, beat counter and error accumulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k    <= 16'd0;
            r_addr <= BASE_ADDR;
            r_beat <= 9'd0;
            r_err  <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_k    <= 16'd0;
                r_addr <= BASE_ADDR;
                r_err  <= 16'd0;
            end else begin
                if (w_rd_exit) begin
                    r_k    <= r_k + 16'd1;
                    r_addr <= r_addr + C_BURST_BYTES;
                end
                r_err <= w_err_next;
            end
            if (w_beat_clr) begin
                r_beat <= 9'd0;
            end else if (w_w_hs || w_r_hs) begin
                r_beat <= r_beat + 9'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
module tb_axi4_traffic_gen;

    localparam logic [31:0] BASE = 32'h80000000;
    localparam int BL  = 16;
    localparam int NB  = 4;
`ifdef AXI4_TG_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk   = 1'b0;
    logic rstn  = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- DUT 0: default parameters ----------------
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, awid, arid;
    logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, bid, rresp, rid;
    logic        arvalid, arready, rvalid, rready, rlast;

    axi4_traffic_gen dut0 (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err_cnt(err_cnt),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // ---------------- DUT 1: 64-bit, single-beat, two bursts ----------------
    logic        busy1, done1;
    logic [15:0] err_cnt1;
    logic [31:0] awaddr1, araddr1;
    logic [7:0]  awlen1, arlen1;
    logic [2:0]  awsize1, arsize1;
    logic [1:0]  awburst1, arburst1, awid1, arid1;
    logic        awvalid1, awready1, wvalid1, wready1, wlast1, bready1, bvalid1;
    logic [63:0] wdata1, rdata1;
    logic [7:0]  wstrb1;
    logic [1:0]  bresp1, bid1, rresp1, rid1;
    logic        arvalid1, arready1, rvalid1, rready1, rlast1;

    axi4_traffic_gen #(.DATA_W(64), .BURST_LEN(1), .NUM_BURSTS(2)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1), .err_cnt(err_cnt1),
        .awaddr(awaddr1), .awlen(awlen1), .awsize(awsize1), .awburst(awburst1), .awid(awid1),
        .awvalid(awvalid1), .awready(awready1),
        .wdata(wdata1), .wstrb(wstrb1), .wlast(wlast1), .wvalid(wvalid1), .wready(wready1),
        .bresp(bresp1), .bid(bid1), .bvalid(bvalid1), .bready(bready1),
        .araddr(araddr1), .arlen(arlen1), .arsize(arsize1), .arburst(arburst1), .arid(arid1),
        .arvalid(arvalid1), .arready(arready1),
        .rdata(rdata1), .rresp(rresp1), .rid(rid1), .rlast(rlast1), .rvalid(rvalid1), .rready(rready1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / slave state (DUT 0) ----------------
    int  aw_n, w_n, b_n, ar_n, r_n;
    int  exp_err;
    logic [31:0] aw_log [NB];
    bit  [31:0] mem [bit [31:0]];
    int  stall;
    int  bad_b_burst, corrupt_burst, corrupt_beat;
    int  rresp_burst, rresp_beat, early_burst, early_beat, drop_burst;
    logic aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs;
    logic pend_aw, pend_w, pend_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic s_wlast;
    logic [31:0] cur_aw, cap_ar, rd_base;
    int  w_beat, rd_left, rd_beat, rd_burst;
    bit  b_pend;

    task automatic reset_model();
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; exp_err = 0;
        for (int i = 0; i < NB; i++) aw_log[i] = 32'h0;
    endtask

    task automatic clear_knobs();
        stall = 0; bad_b_burst = -1; corrupt_burst = -1; corrupt_beat = -1;
        rresp_burst = -1; rresp_beat = -1; early_burst = -1; early_beat = -1; drop_burst = -1;
    endtask

    // Slave memory + monitor for DUT 0: observe at negedge, drive at posedge+1
    initial begin : slave0
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
        b_pend = 0; rd_left = 0; rd_beat = 0; rd_burst = 0; rd_base = 0;
        pend_aw = 0; pend_w = 0; pend_ar = 0; cur_aw = 0; cap_ar = 0; w_beat = 0;
        forever begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            w_last_hs = w_hs && wlast;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (!rstn) begin
                pend_aw = 0; pend_w = 0; pend_ar = 0;
            end else begin
                if (pend_aw) begin
                    check("aw_valid_held", awvalid, 1);
                    check("aw_addr_stable", awaddr, s_awaddr);
                end
                if (pend_w) begin
                    check("w_valid_held", wvalid, 1);
                    check("w_data_stable", wdata, s_wdata);
                    check("w_last_stable", wlast, s_wlast);
                end
                if (pend_ar) begin
                    check("ar_valid_held", arvalid, 1);
                    check("ar_addr_stable", araddr, s_araddr);
                end
                if (aw_hs) begin
                    check("awaddr", awaddr, BASE + 32'(aw_n * BL * 4));
                    check("awlen", awlen, 8'(BL - 1));
                    check("awsize", awsize, 3'd2);
                    check("awburst", awburst, 2'd1);
                    check("awid", awid, 2'd0);
                    if (aw_n < NB) aw_log[aw_n] = awaddr;
                    aw_n++; cur_aw = awaddr; w_beat = 0;
                end
                if (w_hs) begin
                    check("wdata", wdata, BASE + 32'(w_n * 4));
                    check("wlast", wlast, (w_n % BL) == BL - 1);
                    check("wstrb", wstrb, 4'hF);
                    mem[cur_aw + 32'(w_beat * 4)] = wdata;
                    w_n++; w_beat++;
                end
                if (b_hs) begin
                    if (bresp != 0) exp_err++;
                    b_n++;
                end
                if (ar_hs) begin
                    check("araddr", araddr, BASE + 32'(ar_n * BL * 4));
                    check("arlen", arlen, 8'(BL - 1));
                    check("arsize", arsize, 3'd2);
                    check("arburst", arburst, 2'd1);
                    check("arid", arid, 2'd0);
                    ar_n++; cap_ar = araddr;
                end
                if (r_hs) begin
                    if (rresp != 0) exp_err++;
                    if (rlast != ((r_n % BL) == BL - 1)) exp_err++;
                    if (CHK != 0 && rdata != BASE + 32'(r_n * 4)) exp_err++;
                    r_n++;
                end
                if (exp_err > 65535) exp_err = 65535;
                pend_aw = awvalid && !aw_hs; s_awaddr = awaddr;
                pend_w  = wvalid && !w_hs;   s_wdata = wdata; s_wlast = wlast;
                pend_ar = arvalid && !ar_hs; s_araddr = araddr;
            end
            @(posedge clk); #1;
            if (!rstn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
                b_pend = 0; rd_left = 0;
            end else begin
                awready = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                wready  = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                arready = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (w_last_hs) b_pend = 1;
                if (b_hs) bvalid = 0;
                if (b_pend && !bvalid && (stall == 0 || $urandom_range(0, 2) != 0)) begin
                    bvalid = 1; b_pend = 0;
                    bresp = (aw_n - 1 == bad_b_burst) ? 2'd2 : 2'd0;
                end
                if (ar_hs) begin
                    rd_left = BL; rd_beat = 0; rd_base = cap_ar; rd_burst = ar_n - 1;
                end
                if (r_hs) begin
                    rvalid = 0; rd_beat++; rd_left--;
                end
                if (rd_left > 0 && !rvalid && (stall == 0 || $urandom_range(0, 2) != 0)) begin
                    rvalid = 1;
                    rdata = mem.exists(rd_base + 32'(rd_beat * 4)) ?
                            mem[rd_base + 32'(rd_beat * 4)] : 32'hDEADBEEF;
                    if (rd_burst == corrupt_burst && rd_beat == corrupt_beat) rdata = rdata ^ 32'h1;
                    rresp = (rd_burst == rresp_burst && rd_beat == rresp_beat) ? 2'd2 : 2'd0;
                    rlast = (rd_beat == BL - 1);
                    if (rd_burst == early_burst && rd_beat == early_beat) rlast = 1;
                    if (rd_burst == drop_burst && rd_beat == BL - 1) rlast = 0;
                end
            end
        end
    end

    // ---------------- always-ready slave + monitor for DUT 1 ----------------
    int aw1_n = 0, w1_n = 0;
    initial begin : slave1
        awready1 = 0; wready1 = 0; bvalid1 = 0; bresp1 = 0; bid1 = 0;
        arready1 = 0; rvalid1 = 0; rdata1 = 0; rresp1 = 0; rid1 = 0; rlast1 = 0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (awvalid1 && awready1) begin
                    check("dut1_awaddr", awaddr1, BASE + 32'(aw1_n * 8));
                    check("dut1_awlen", awlen1, 8'd0);
                    check("dut1_awsize", awsize1, 3'd3);
                    aw1_n++;
                end
                if (wvalid1 && wready1) begin
                    check("dut1_wdata", wdata1, 64'(BASE + 32'(w1_n * 8)));
                    check("dut1_wlast", wlast1, 1);
                    check("dut1_wstrb", wstrb1, 8'hFF);
                    w1_n++;
                end
            end
            @(posedge clk); #1;
            awready1 = rstn; wready1 = rstn; arready1 = rstn; bvalid1 = rstn;
            rvalid1 = rstn; rlast1 = 1; rdata1 = 64'(araddr1);
        end
    end

    task automatic kick();
        reset_model();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err_cnt, 16'd0);
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_aw_count"}, aw_n, NB);
        check({tag, "_w_count"}, w_n, NB * BL);
        check({tag, "_b_count"}, b_n, NB);
        check({tag, "_ar_count"}, ar_n, NB);
        check({tag, "_r_count"}, r_n, NB * BL);
        check({tag, "_err_model"}, err_cnt, 16'(exp_err));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        clear_knobs();
        reset_model();
        #2 rstn = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 16'd0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("rst_dut1_busy", busy1, 0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        check("rel_idle_busy", busy, 0);

        // 64-bit, single-beat configuration
        start1 = 1; @(negedge clk); start1 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done1) break;
        end
        check("dut1_done", done1, 1);
        check("dut1_w_beats", w1_n, 2);
        check("dut1_err", err_cnt1, 16'd0);

        // zero-wait OKAY memory
        kick();
        finish_run("basic");
        check("basic_aw0", aw_log[0], 32'h80000000);
        check("basic_aw1", aw_log[1], 32'h80000040);
        check("basic_aw2", aw_log[2], 32'h80000080);
        check("basic_aw3", aw_log[3], 32'h800000C0);
        check("basic_err", err_cnt, 16'd0);
        repeat (3) @(negedge clk);
        check("done_held", done, 1);

        // random stalls on all slave channels
        stall = 1;
        kick();
        finish_run("stall");
        check("stall_err", err_cnt, 16'd0);
        check("stall_aw3", aw_log[3], 32'h800000C0);

        // SLVERR on first write response, corrupted read beat 5 of burst 2
        clear_knobs();
        bad_b_burst = 0; corrupt_burst = 2; corrupt_beat = 5;
        kick();
        finish_run("errs");
        check("errs_count", err_cnt, 16'(1 + CHK));

        // rresp error coinciding with early rlast, missing final rlast,
        // and a start pulse while busy that must be ignored
        clear_knobs();
        stall = 1; rresp_burst = 1; rresp_beat = 3; early_burst = 1; early_beat = 3; drop_burst = 3;
        kick();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ar_n >= 3) break;
        end
        check("mid_err_before_start", err_cnt, 16'd2);
        start = 1; @(negedge clk); start = 0;
        check("mid_start_busy", busy, 1);
        finish_run("rlast");
        check("rlast_err", err_cnt, 16'd3);

        // asynchronous reset during write beat 7, then restart
        clear_knobs();
        kick();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (w_n == 7 && wvalid) break;
        end
        check("pre_rst_wvalid", wvalid, 1);
        #2 rstn = 0;
        #1;
        check("async_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("async_busy", busy, 0);
        check("async_err", err_cnt, 16'd0);
        @(negedge clk); rstn = 1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {busy, done}, 2'b00);
        kick();
        finish_run("restart");
        check("restart_aw0", aw_log[0], 32'h80000000);
        check("restart_err", err_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
